inst_queue: RTL and testbench

Instruction queue between the fetch (PC/IF) stage and decode. It buffers fetched instructions with their PC, delay-slot flag and fetch-exception info, so icache or fetch stalls and decode stalls are decoupled. Output is first-word-fall-through: decode sees the head entry combinationally from queue storage. A pipeline flush empties the queue.

---
 rtl/inst_queue_pkg.sv | 19 +
 rtl/inst_queue_ram.sv | 26 ++
 rtl/inst_queue.sv | 122 ++++++++++++
 tb/tb_inst_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue: exception vector width,
// exception bit indices, NOP encoding and the packed entry layout.
package inst_queue_pkg;

    localparam int unsigned ExcE_W = 16;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;

    // Bit positions inside the exception vector
    localparam int unsigned EXC_ADEL_FETCH = 1;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0;

    // Entry layout, MSB first: {pc, inst, inslot, has_exc, excs}
    function automatic int unsigned entry_width(input int unsigned exc_w);
        return PC_W + INST_W + 2 + exc_w;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage for inst_queue: DEPTH x WIDTH register array with a synchronous write port
// and an asynchronous read port. Contents are not reset.
module inst_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 82,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_queue.sv
// First-word-fall-through instruction queue between fetch and decode, cleared by flush_i.
// Define INSTQ_BYPASS_EN to forward a push straight to the outputs when the queue is empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EXC_W = ExcE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,

    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [31:0]            push_pc_i,
    input  logic [31:0]            push_inst_i,
    input  logic                   push_inslot_i,
    input  logic                   push_has_exc_i,
    input  logic [EXC_W-1:0]       push_excs_i,

    input  logic                   pop_ready_i,
    output logic                   pop_valid_o,
    output logic [31:0]            pop_pc_o,
    output logic [31:0]            pop_inst_o,
    output logic                   pop_inslot_o,
    output logic                   pop_has_exc_o,
    output logic [EXC_W-1:0]       pop_excs_o,

    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = entry_width(EXC_W);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_bypass;
    logic             w_wr_en;
    logic             w_rd_adv;
    logic             w_pop_valid;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;
    logic [ENT_W-1:0] w_head;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends on stored occupancy only, so a full queue refuses a push even while popping.
    assign push_ready_o = ~w_full;

    assign w_wdata = {push_pc_i, push_inst_i, push_inslot_i, push_has_exc_i, push_excs_i};

`ifdef INSTQ_BYPASS_EN
    assign w_bypass = w_empty & push_valid_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_wr_en  = push_valid_i & ~w_full & ~flush_i & ~(w_bypass & pop_ready_i);
    assign w_rd_adv = ~w_empty & pop_ready_i & ~flush_i;

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_adv})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Invalid head reads as a NOP bubble with all side fields cleared.
    always_comb begin
        w_pop_valid = ~w_empty;
        w_head      = w_rdata;
        if (w_bypass) begin
            w_pop_valid = 1'b1;
            w_head      = w_wdata;
        end
        if (!w_pop_valid) begin
            w_head = {32'h0, NOP_INST, 1'b0, 1'b0, {EXC_W{1'b0}}};
        end
    end

    assign pop_valid_o = w_pop_valid;
    assign {pop_pc_o, pop_inst_o, pop_inslot_o, pop_has_exc_o, pop_excs_o} = w_head;
    assign count_o = r_count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic against a
// queue-based reference model. Honours INSTQ_BYPASS_EN when the design is built with it.
module tb_inst_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned EXC_W = 16;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             inslot;
        logic             has_exc;
        logic [EXC_W-1:0] excs;
    } entry_t;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             push_valid_i;
    logic             push_ready_o;
    logic [31:0]      push_pc_i;
    logic [31:0]      push_inst_i;
    logic             push_inslot_i;
    logic             push_has_exc_i;
    logic [EXC_W-1:0] push_excs_i;
    logic             pop_ready_i;
    logic             pop_valid_o;
    logic [31:0]      pop_pc_o;
    logic [31:0]      pop_inst_o;
    logic             pop_inslot_o;
    logic             pop_has_exc_o;
    logic [EXC_W-1:0] pop_excs_o;
    logic [2:0]       count_o;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t model_q[$];

    inst_queue #(
        .DEPTH (DEPTH),
        .EXC_W (EXC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .push_valid_i   (push_valid_i),
        .push_ready_o   (push_ready_o),
        .push_pc_i      (push_pc_i),
        .push_inst_i    (push_inst_i),
        .push_inslot_i  (push_inslot_i),
        .push_has_exc_i (push_has_exc_i),
        .push_excs_i    (push_excs_i),
        .pop_ready_i    (pop_ready_i),
        .pop_valid_o    (pop_valid_o),
        .pop_pc_o       (pop_pc_o),
        .pop_inst_o     (pop_inst_o),
        .pop_inslot_o   (pop_inslot_o),
        .pop_has_exc_o  (pop_has_exc_o),
        .pop_excs_o     (pop_excs_o),
        .count_o        (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit bypass_enabled();
`ifdef INSTQ_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic entry_t cur_push();
        entry_t e;
        e.pc      = push_pc_i;
        e.inst    = push_inst_i;
        e.inslot  = push_inslot_i;
        e.has_exc = push_has_exc_i;
        e.excs    = push_excs_i;
        return e;
    endfunction

    // Expected decode view this cycle, from the model and the current inputs.
    task automatic check_outputs(input string tag);
        entry_t h;
        logic   v;
        v = 1'b0;
        h = '{pc: 32'h0, inst: 32'h0, inslot: 1'b0, has_exc: 1'b0, excs: '0};
        if (model_q.size() != 0) begin
            v = 1'b1;
            h = model_q[0];
        end else if (bypass_enabled() && push_valid_i && !flush_i) begin
            v = 1'b1;
            h = cur_push();
        end
        check($sformatf("%s.valid", tag), 64'(pop_valid_o), 64'(v));
        check($sformatf("%s.count", tag), 64'(count_o), 64'(model_q.size()));
        check($sformatf("%s.ready", tag), 64'(push_ready_o), 64'(model_q.size() != DEPTH));
        check($sformatf("%s.pc", tag), 64'(pop_pc_o), 64'(h.pc));
        check($sformatf("%s.inst", tag), 64'(pop_inst_o), 64'(h.inst));
        check($sformatf("%s.inslot", tag), 64'(pop_inslot_o), 64'(h.inslot));
        check($sformatf("%s.has_exc", tag), 64'(pop_has_exc_o), 64'(h.has_exc));
        check($sformatf("%s.excs", tag), 64'(pop_excs_o), 64'(h.excs));
    endtask

    task automatic model_update();
        bit had;
        had = (model_q.size() != 0);
        if (flush_i) begin
            model_q.delete();
        end else if (!had && bypass_enabled() && push_valid_i) begin
            if (!pop_ready_i) model_q.push_back(cur_push());
        end else begin
            bit do_push;
            do_push = push_valid_i && (model_q.size() < DEPTH);
            if (had && pop_ready_i) void'(model_q.pop_front());
            if (do_push) model_q.push_back(cur_push());
        end
    endtask

    // Inputs are set after posedge+1; outputs are sampled at the falling edge.
    task automatic cycle(input string tag);
        @(negedge clk);
        check_outputs(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic inslot, input logic has_exc, input logic [EXC_W-1:0] excs,
                         input logic pr, input logic fl);
        push_valid_i   = pv;
        push_pc_i      = pc;
        push_inst_i    = inst;
        push_inslot_i  = inslot;
        push_has_exc_i = has_exc;
        push_excs_i    = excs;
        pop_ready_i    = pr;
        flush_i        = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #3;
        check_outputs("reset");
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill with pop stalled, then try a fifth push.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hbfc00000 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 32'hbfc00010, 32'hdead, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle("fill_over");
        check("full_count", 64'(count_o), 64'd4);

        // Full with simultaneous push and pop: push refused.
        drive(1'b1, 32'hbfc00020, 32'hbeef, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle("full_pushpop");
        check("full_pushpop_count", 64'(count_o), 64'd3);

        idle();
        pop_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) cycle("drain");
        check("drained_valid", 64'(pop_valid_o), 64'd0);

        // Flush with push and pop in the same cycle.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h80000000 + 32'(4 * i), 32'h2000 + 32'(i), 1'b1, 1'b0, '0, 1'b0, 1'b0);
            cycle("pre_flush");
        end
        drive(1'b1, 32'h80000100, 32'h3000, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1);
        cycle("flush");
        idle();
        pop_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_flush");

        // Field integrity across pointer wrap.
        for (int i = 0; i < 10; i++) begin
            if (i == 4) drive(1'b1, 32'hbfc00002, $urandom, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
            else drive(1'b1, 32'hbfc00000 + 32'(4 * i), $urandom, i[0], 1'b0, '0,
                       ($urandom_range(0, 2) != 0), 1'b0);
            cycle("stream");
        end
        idle();
        pop_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) cycle("stream_drain");

        // Single push into empty queue with decode ready.
        drive(1'b1, 32'hbfc00100, 32'h24020001, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        if (bypass_enabled()) begin
            check("bypass_same_cycle_inst", 64'(pop_inst_o), 64'h24020001);
        end else begin
            check("nobypass_same_cycle_valid", 64'(pop_valid_o), 64'd0);
        end
        check_outputs("single");
        model_update();
        @(posedge clk);
        #1;
        idle();
        pop_ready_i = 1'b1;
        @(negedge clk);
        check("single_next_inst", 64'(pop_inst_o), bypass_enabled() ? 64'h0 : 64'h24020001);
        check_outputs("single_next");
        model_update();
        @(posedge clk);
        #1;

        // Asynchronous reset with three entries queued.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hbfc00200 + 32'(4 * i), 32'h5000 + 32'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            cycle("pre_reset");
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check("areset_valid", 64'(pop_valid_o), 64'd0);
        check("areset_count", 64'(count_o), 64'd0);
        check("areset_ready", 64'(push_ready_o), 64'd1);
        check("areset_inst", 64'(pop_inst_o), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                  1'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
